gecko_writeback_arbiter: RTL and testbench

GECKO_WRITEBACK_ARBITER -- requirements
Module: gecko_writeback_arbiter

---
 rtl/gecko_writeback_arbiter.sv | 167 ++++++++++++++++
 tb/tb_gecko_writeback_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/gecko_writeback_arbiter.sv
// rtl/gecko_writeback_arbiter.sv - register-ordered writeback arbiter
//
// Purpose: merges NUM_CHANNELS result streams into one registered writeback
// stream. A per-register status table holds the tag expected next for each
// architectural register. Only results whose tag matches may be granted, so
// writes to the same register retire in tag order across channels.
// Eligible channels are served round-robin.
//
// Optional feature: when GECKO_WRITEBACK_X0_FILTER_EN is defined, results for
// register 0 are consumed and update the table, but are not forwarded.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   in_valid/ready   per-channel result handshake
//   in_addr          per-channel destination register (log2(REG_COUNT) each)
//   in_status        per-channel ordering tag (STATUS_WIDTH each)
//   in_data          per-channel result value (DATA_WIDTH each)
//   out_valid/ready  writeback stream handshake
//   out_addr/status/data  registered writeback payload
module gecko_writeback_arbiter #(
  parameter int NUM_CHANNELS = 3,
  parameter int REG_COUNT    = 32,
  parameter int STATUS_WIDTH = 2,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NUM_CHANNELS-1:0]                    in_valid,
  output logic [NUM_CHANNELS-1:0]                    in_ready,
  input  logic [NUM_CHANNELS*$clog2(REG_COUNT)-1:0]  in_addr,
  input  logic [NUM_CHANNELS*STATUS_WIDTH-1:0]       in_status,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]         in_data,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [$clog2(REG_COUNT)-1:0]               out_addr,
  output logic [STATUS_WIDTH-1:0]                    out_status,
  output logic [DATA_WIDTH-1:0]                      out_data
);

  localparam int AW = $clog2(REG_COUNT);
  localparam int SW = STATUS_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int PW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  // The tag space must be able to distinguish every channel's in-flight write.
  generate
    if ((2 ** STATUS_WIDTH) < NUM_CHANNELS) begin : g_bad_status_width
      $error("STATUS_WIDTH too small for NUM_CHANNELS");
    end
  endgenerate

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           cnt_q;
  logic [PW-1:0]           ptr_q;
  logic [SW-1:0]           status_tbl [REG_COUNT];

  logic [NUM_CHANNELS-1:0] eligible;
  logic                    grant_any;
  logic [PW-1:0]           grant_idx;
  logic                    advance;
  logic                    grant;
  logic                    fwd;
  logic [AW-1:0]           g_addr;
  logic [SW-1:0]           g_status;
  logic [DW-1:0]           g_data;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: leave INIT once the last table entry has been cleared
  always_comb begin
    state_d = state_q;
    if (state_q == S_INIT && cnt_q == AW'(REG_COUNT - 1)) begin
      state_d = S_RUN;
    end
  end

  // Eligibility: result tag must equal the tag the register expects next
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      eligible[i] = in_valid[i] &&
                    (status_tbl[in_addr[i*AW +: AW]] == in_status[i*SW +: SW]);
    end
  end

  // Round-robin pick: scan from the farthest offset down so the channel
  // closest to the pointer is the one left standing.
  always_comb begin
    logic [PW-1:0] idx;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int off = NUM_CHANNELS - 1; off >= 0; off--) begin
      idx = PW'((int'(ptr_q) + off) % NUM_CHANNELS);
      if (eligible[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
  end

  // Outputs of the FSM: grant only in RUN when the output register can move
  always_comb begin
    advance  = !out_valid || out_ready;
    grant    = (state_q == S_RUN) && advance && grant_any;
    in_ready = '0;
    if (grant) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  assign g_addr   = in_addr[grant_idx*AW +: AW];
  assign g_status = in_status[grant_idx*SW +: SW];
  assign g_data   = in_data[grant_idx*DW +: DW];

`ifdef GECKO_WRITEBACK_X0_FILTER_EN
  assign fwd = grant && (g_addr != '0);
`else
  assign fwd = grant;
`endif

  // Control state with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      ptr_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (state_q == S_INIT) begin
        cnt_q <= cnt_q + AW'(1);
      end
      if (grant) begin
        ptr_q <= (grant_idx == PW'(NUM_CHANNELS - 1)) ? '0 : grant_idx + PW'(1);
      end
      if (advance) begin
        out_valid <= fwd;
      end
    end
  end

  // Payload registers are data-only and carry no reset
  always_ff @(posedge clk) begin
    if (grant) begin
      out_addr   <= g_addr;
      out_status <= g_status;
      out_data   <= g_data;
    end
  end

  // Status table: cleared one entry per cycle in INIT, bumped on each grant
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      status_tbl[cnt_q] <= '0;
    end else if (grant) begin
      status_tbl[g_addr] <= g_status + SW'(1);
    end
  end

endmodule

// File: tb/tb_gecko_writeback_arbiter.sv
// tb/tb_gecko_writeback_arbiter.sv - directed self-checking bench for gecko_writeback_arbiter
module tb_gecko_writeback_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int SW = 2;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [N*AW-1:0] in_addr;
  logic [N*SW-1:0] in_status;
  logic [N*DW-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [AW-1:0]   out_addr;
  logic [SW-1:0]   out_status;
  logic [DW-1:0]   out_data;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  gecko_writeback_arbiter #(
    .NUM_CHANNELS(N), .REG_COUNT(32), .STATUS_WIDTH(SW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_status(in_status), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_status(out_status), .out_data(out_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input int ch, input int addr, input int tag);
    return 32'hD000_0000 | DW'(ch << 12) | DW'(addr << 4) | DW'(tag);
  endfunction

  task automatic set_ch(input int ch, input bit v, input int addr, input int tag);
    in_valid[ch]            = v;
    in_addr[ch*AW +: AW]    = AW'(addr);
    in_status[ch*SW +: SW]  = SW'(tag);
    in_data[ch*DW +: DW]    = mk_data(ch, addr, tag);
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic to_sample;
    @(negedge clk);
  endtask

  // Counts sample points with in_ready all zero, starting from the current one.
  task automatic count_init(output int cycles);
    int ov_seen;
    cycles  = 0;
    ov_seen = 0;
    while (in_ready == '0 && cycles < 100) begin
      if (out_valid) ov_seen++;
      cycles++;
      @(negedge clk);
    end
    check("init_out_valid", 64'(ov_seen), 64'd0);
  endtask

  initial begin
    logic [N-1:0] rr_rdy [6];
    logic         rr_ov  [6];
    int           rr_oa  [6];
    rr_rdy = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b000, 3'b000};
    rr_ov  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    rr_oa  = '{0, 1, 2, 3, 4, 0};

    rst       = 1'b1;
    in_valid  = '0;
    in_addr   = '0;
    in_status = '0;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) to_sample();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);

    // Table clear takes 32 cycles; first grant on cycle 33
    set_ch(0, 1, 1, 0);
    set_ch(1, 1, 2, 0);
    set_ch(2, 1, 3, 0);
    next_cycle();
    rst = 1'b0;
    to_sample();
    count_init(n);
    check("init_len", 64'(n), 64'd32);

    // Round-robin 0,1,2,0 with producers refilling or dropping after acceptance
    for (int k = 0; k < 6; k++) begin
      check($sformatf("rr_rdy%0d", k), 64'(in_ready), 64'(rr_rdy[k]));
      check($sformatf("rr_ov%0d", k), 64'(out_valid), 64'(rr_ov[k]));
      if (rr_ov[k]) check($sformatf("rr_addr%0d", k), 64'(out_addr), 64'(rr_oa[k]));
      next_cycle();
      case (k)
        0: set_ch(0, 1, 4, 0);
        1: in_valid[1] = 1'b0;
        2: in_valid[2] = 1'b0;
        3: in_valid[0] = 1'b0;
        default: ;
      endcase
      to_sample();
    end

    // Ordering: same register, tag 0 must retire before tag 1
    next_cycle();
    set_ch(0, 1, 5, 1);
    set_ch(1, 1, 5, 0);
    to_sample();
    check("ord_first", 64'(in_ready), 64'b010);
    next_cycle();
    in_valid[1] = 1'b0;
    to_sample();
    check("ord_second", 64'(in_ready), 64'b001);
    check("ord_out_addr", 64'(out_addr), 64'd5);
    check("ord_out_status", 64'(out_status), 64'd0);

    // Backpressure: output held, nothing accepted, table untouched
    next_cycle();
    in_valid[0] = 1'b0;
    set_ch(2, 1, 6, 0);
    out_ready = 1'b0;
    to_sample();
    check("ord_tbl5", 64'(dut.status_tbl[5]), 64'd2);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("bp_ov%0d", j), 64'(out_valid), 64'd1);
      check($sformatf("bp_addr%0d", j), 64'(out_addr), 64'd5);
      check($sformatf("bp_status%0d", j), 64'(out_status), 64'd1);
      check($sformatf("bp_data%0d", j), 64'(out_data), 64'(mk_data(0, 5, 1)));
      check($sformatf("bp_rdy%0d", j), 64'(in_ready), 64'd0);
      check($sformatf("bp_tbl6_%0d", j), 64'(dut.status_tbl[6]), 64'd0);
      if (j < 3) begin
        next_cycle();
        to_sample();
      end
    end
    next_cycle();
    out_ready = 1'b1;
    to_sample();
    check("bp_release_rdy", 64'(in_ready), 64'b100);
    next_cycle();
    in_valid[2] = 1'b0;
    to_sample();
    check("bp_release_addr", 64'(out_addr), 64'd6);
    check("bp_tbl6", 64'(dut.status_tbl[6]), 64'd1);

    // Tag wrap: four writes to register 7 with tags 0..3
    for (int t = 0; t < 4; t++) begin
      next_cycle();
      set_ch(0, 1, 7, t);
      to_sample();
      check($sformatf("wrap_rdy%0d", t), 64'(in_ready), 64'b001);
    end
    next_cycle();
    in_valid[0] = 1'b0;
    to_sample();
    check("wrap_out_status", 64'(out_status), 64'd3);
    check("wrap_tbl7", 64'(dut.status_tbl[7]), 64'd0);

    // Register-0 result
    next_cycle();
    set_ch(2, 1, 0, 0);
    to_sample();
    check("x0_rdy", 64'(in_ready), 64'b100);
    next_cycle();
    in_valid[2] = 1'b0;
    to_sample();
`ifdef GECKO_WRITEBACK_X0_FILTER_EN
    check("x0_out_valid", 64'(out_valid), 64'd0);
`else
    check("x0_out_valid", 64'(out_valid), 64'd1);
    check("x0_out_addr", 64'(out_addr), 64'd0);
`endif
    check("x0_tbl0", 64'(dut.status_tbl[0]), 64'd1);

    // Reset mid-operation drops the held output and restarts the clear
    next_cycle();
    out_ready = 1'b0;
    set_ch(1, 1, 9, 0);
    to_sample();
    next_cycle();
    to_sample();
    check("mid_hold_ov", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ov", 64'(out_valid), 64'd0);
    check("mid_rst_rdy", 64'(in_ready), 64'd0);
    next_cycle();
    rst = 1'b0;
    out_ready = 1'b1;
    to_sample();
    count_init(n);
    check("mid_init_len", 64'(n), 64'd32);
    check("mid_first_rdy", 64'(in_ready), 64'b010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
